// File: rtl/d_e_pipe_reg_pkg.sv
// Shared definitions for the D->E pipeline register: operand-2 select codes,
// the NOP instruction word and the select normalisation helper.
package d_e_pipe_reg_pkg;

    localparam logic [1:0]  SEL_RDATA2   = 2'b00;
    localparam logic [1:0]  SEL_EXT      = 2'b01;
    localparam logic [1:0]  SEL_ZERO_EXT = 2'b10;
    localparam logic [1:0]  SEL_RSVD     = 2'b11;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // The reserved select code falls back to the register operand.
    function automatic logic [1:0] norm_sel(input logic [1:0] sel);
        return (sel == SEL_RSVD) ? SEL_RDATA2 : sel;
    endfunction

endpackage

// File: rtl/d_e_pipe_reg_tnew_age.sv
// Combinational saturating decrement of the Tnew hazard field; shared by the
// D->E, E->M and M->W pipeline registers.
module tnew_age #(
    parameter int TNEW_W = 2
) (
    input  logic [TNEW_W-1:0] tnew_in,
    output logic [TNEW_W-1:0] tnew_out
);

    assign tnew_out = (tnew_in == '0) ? '0 : tnew_in - TNEW_W'(1);

endmodule

// File: rtl/d_e_pipe_reg.sv
// D->E pipeline register of the five-stage MIPS core with bubble, flush, hold
// and Tnew ageing. Optional bubble counter enabled by macro DE_BUBBLE_CNT_EN.
module d_e_pipe_reg
    import d_e_pipe_reg_pkg::*;
#(
    parameter int TNEW_W  = 2,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               d_stall,
    input  logic               e_hold,
    input  logic               flush,
    input  logic [31:0]        D_pc,
    input  logic [31:0]        D_instr,
    input  logic [31:0]        D_Rdata1,
    input  logic [31:0]        D_Rdata2,
    input  logic [15:0]        D_imm16,
    input  logic [1:0]         D_s_data2,
    input  logic [ALUOP_W-1:0] D_aluop,
    input  logic [4:0]         D_rd_addr,
    input  logic [TNEW_W-1:0]  D_Tnew,
    output logic [31:0]        E_pc,
    output logic [31:0]        E_instr,
    output logic [31:0]        E_Rdata1,
    output logic [31:0]        E_Rdata2,
    output logic [15:0]        E_imm16,
    output logic [1:0]         s_E_data2,
    output logic [ALUOP_W-1:0] E_aluop,
    output logic [4:0]         E_rd_addr,
    output logic [TNEW_W-1:0]  E_Tnew,
`ifdef DE_BUBBLE_CNT_EN
    output logic [31:0]        E_bubble_cnt,
`endif
    output logic               E_valid
);

    logic [TNEW_W-1:0] tnew_aged;
    logic              bubble;

    assign bubble = flush | d_stall;

    tnew_age #(.TNEW_W(TNEW_W)) u_tnew_age (
        .tnew_in  (D_Tnew),
        .tnew_out (tnew_aged)
    );

    // Hold has priority over any bubble request; a bubble still carries the PC
    // so a later exception can report a meaningful EPC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            E_pc      <= '0;
            E_instr   <= NOP_INSTR;
            E_Rdata1  <= '0;
            E_Rdata2  <= '0;
            E_imm16   <= '0;
            s_E_data2 <= SEL_RDATA2;
            E_aluop   <= '0;
            E_rd_addr <= '0;
            E_Tnew    <= '0;
            E_valid   <= 1'b0;
        end else if (!e_hold) begin
            E_pc <= D_pc;
            if (bubble) begin
                E_instr   <= NOP_INSTR;
                E_Rdata1  <= '0;
                E_Rdata2  <= '0;
                E_imm16   <= '0;
                s_E_data2 <= SEL_RDATA2;
                E_aluop   <= '0;
                E_rd_addr <= '0;
                E_Tnew    <= '0;
                E_valid   <= 1'b0;
            end else begin
                E_instr   <= D_instr;
                E_Rdata1  <= D_Rdata1;
                E_Rdata2  <= D_Rdata2;
                E_imm16   <= D_imm16;
                s_E_data2 <= norm_sel(D_s_data2);
                E_aluop   <= D_aluop;
                E_rd_addr <= D_rd_addr;
                E_Tnew    <= tnew_aged;
                E_valid   <= 1'b1;
            end
        end
    end

`ifdef DE_BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            E_bubble_cnt <= '0;
        end else if (!e_hold && bubble && (E_bubble_cnt != 32'hFFFF_FFFF)) begin
            E_bubble_cnt <= E_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// Directed self-checking bench for d_e_pipe_reg; the bubble counter section
// is exercised when DE_BUBBLE_CNT_EN is defined.
module tb_d_e_pipe_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        d_stall, e_hold, flush;
    logic [31:0] D_pc, D_instr, D_Rdata1, D_Rdata2;
    logic [15:0] D_imm16;
    logic [1:0]  D_s_data2;
    logic [3:0]  D_aluop;
    logic [4:0]  D_rd_addr;
    logic [1:0]  D_Tnew;
    logic [31:0] E_pc, E_instr, E_Rdata1, E_Rdata2;
    logic [15:0] E_imm16;
    logic [1:0]  s_E_data2;
    logic [3:0]  E_aluop;
    logic [4:0]  E_rd_addr;
    logic [1:0]  E_Tnew;
    logic        E_valid;
`ifdef DE_BUBBLE_CNT_EN
    logic [31:0] E_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    d_e_pipe_reg #(.TNEW_W(2), .ALUOP_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .d_stall(d_stall), .e_hold(e_hold), .flush(flush),
        .D_pc(D_pc), .D_instr(D_instr), .D_Rdata1(D_Rdata1), .D_Rdata2(D_Rdata2),
        .D_imm16(D_imm16), .D_s_data2(D_s_data2), .D_aluop(D_aluop),
        .D_rd_addr(D_rd_addr), .D_Tnew(D_Tnew),
        .E_pc(E_pc), .E_instr(E_instr), .E_Rdata1(E_Rdata1), .E_Rdata2(E_Rdata2),
        .E_imm16(E_imm16), .s_E_data2(s_E_data2), .E_aluop(E_aluop),
        .E_rd_addr(E_rd_addr), .E_Tnew(E_Tnew),
`ifdef DE_BUBBLE_CNT_EN
        .E_bubble_cnt(E_bubble_cnt),
`endif
        .E_valid(E_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [15:0] imm, input logic [1:0] sel,
                         input logic [3:0] op, input logic [4:0] rd, input logic [1:0] tn);
        D_pc = pc; D_instr = instr; D_Rdata1 = r1; D_Rdata2 = r2; D_imm16 = imm;
        D_s_data2 = sel; D_aluop = op; D_rd_addr = rd; D_Tnew = tn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; d_stall = 1'b0; e_hold = 1'b0; flush = 1'b0;
        set_d(32'h0, 32'h0, 32'h0, 32'h0, 16'h0, 2'b00, 4'h0, 5'd0, 2'd0);
        step();
        check("rst_valid", {31'b0, E_valid}, 32'd0);
        check("rst_pc", E_pc, 32'd0);
        reset_n = 1'b1;

        // Load ori
        set_d(32'h3000, 32'h3485_8001, 32'h1111_2222, 32'h3333_4444, 16'h8001, 2'b10, 4'h5, 5'd5, 2'd2);
        step();
        check("ori_sel", 32'(s_E_data2), 32'd2);
        check("ori_imm", 32'(E_imm16), 32'h8001);
        check("ori_tnew", 32'(E_Tnew), 32'd1);
        check("ori_rd", 32'(E_rd_addr), 32'd5);
        check("ori_valid", {31'b0, E_valid}, 32'd1);
        check("ori_r1", E_Rdata1, 32'h1111_2222);
        check("ori_r2", E_Rdata2, 32'h3333_4444);
        check("ori_op", 32'(E_aluop), 32'd5);
        check("ori_instr", E_instr, 32'h3485_8001);

        // Stall
        d_stall = 1'b1;
        set_d(32'h3004, 32'hABCD_0000, 32'h5, 32'h6, 16'h7, 2'b01, 4'h3, 5'd7, 2'd2);
        step();
        d_stall = 1'b0;
        check("stall_valid", {31'b0, E_valid}, 32'd0);
        check("stall_rd", 32'(E_rd_addr), 32'd0);
        check("stall_instr", E_instr, 32'd0);
        check("stall_sel", 32'(s_E_data2), 32'd0);
        check("stall_pc", E_pc, 32'h3004);
        check("stall_tnew", 32'(E_Tnew), 32'd0);
        check("stall_imm", 32'(E_imm16), 32'd0);

        // Hold beats flush
        set_d(32'h3008, 32'h0000_1234, 32'h9, 32'hA, 16'h55, 2'b01, 4'h2, 5'd9, 2'd1);
        step();
        check("pre_hold_tnew", 32'(E_Tnew), 32'd0);
        check("pre_hold_sel", 32'(s_E_data2), 32'd1);
        e_hold = 1'b1; flush = 1'b1;
        set_d(32'h300C, 32'hFFFF_FFFF, 32'h1, 32'h2, 16'h3, 2'b10, 4'h1, 5'd12, 2'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", {31'b0, E_valid}, 32'd1);
            check("hold_rd", 32'(E_rd_addr), 32'd9);
            check("hold_pc", E_pc, 32'h3008);
            check("hold_instr", E_instr, 32'h0000_1234);
        end
        e_hold = 1'b0;
        step();
        flush = 1'b0;
        check("flush_valid", {31'b0, E_valid}, 32'd0);
        check("flush_rd", 32'(E_rd_addr), 32'd0);
        check("flush_pc", E_pc, 32'h300C);

        // Edge encodings
        set_d(32'h3010, 32'h1, 32'h0, 32'h0, 16'h0, 2'b11, 4'h0, 5'd3, 2'd3);
        step();
        check("rsvd_sel", 32'(s_E_data2), 32'd0);
        check("tnew3", 32'(E_Tnew), 32'd2);
        set_d(32'h3014, 32'h2, 32'h0, 32'h0, 16'h0, 2'b01, 4'h0, 5'd3, 2'd0);
        step();
        check("tnew0", 32'(E_Tnew), 32'd0);
        check("sel01", 32'(s_E_data2), 32'd1);

        // Asynchronous reset mid-cycle with nonzero state
        #2 reset_n = 1'b0;
        #1;
        check("async_pc", E_pc, 32'd0);
        check("async_instr", E_instr, 32'd0);
        check("async_valid", {31'b0, E_valid}, 32'd0);
        check("async_rd", 32'(E_rd_addr), 32'd0);
        check("async_sel", 32'(s_E_data2), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef DE_BUBBLE_CNT_EN
        check("cnt_rst", E_bubble_cnt, 32'd0);
        flush = 1'b1; step();
        e_hold = 1'b1; step();
        e_hold = 1'b0; flush = 1'b0; d_stall = 1'b1; step();
        e_hold = 1'b1; step();
        e_hold = 1'b0; d_stall = 1'b0; step();
        check("cnt_bubbles", E_bubble_cnt, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
